// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, with the controller and datapath in one block.
// Retires two multiplier bits per clock and exposes the per-step recoding strobes.
module booth_r4_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Request,
    input  logic                 Signed_mode,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Done,
    output logic                 add_s,
    output logic                 sub_s,
    output logic                 dbl_s
);

    localparam int unsigned EW   = WIDTH + 2;      // extended operand width
    localparam int unsigned AW   = WIDTH + 3;      // accumulator width, holds +/-2M
    localparam int unsigned PW   = AW + EW + 1;    // {acc, multiplier, q-1}
    localparam int unsigned ITER = WIDTH / 2 + 1;
    localparam int unsigned CW   = $clog2(ITER);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [EW-1:0]        m_q, m_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [EW:0]          mq_q, mq_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;

    logic [2:0]           triplet;
    logic [AW-1:0]        m_single;
    logic [AW-1:0]        m_double;
    logic [AW-1:0]        pp_mag;
    logic [AW-1:0]        pp;
    logic [AW-1:0]        sum;
    logic [PW-1:0]        shifted;
    logic                 mcand_sx;
    logic                 mplier_sx;

    assign Product = prod_q;
    assign Done    = done_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        done_d    = done_q;
        add_s     = 1'b0;
        sub_s     = 1'b0;
        dbl_s     = 1'b0;

        triplet   = mq_q[2:0];
        mcand_sx  = Signed_mode & Multiplicand[WIDTH-1];
        mplier_sx = Signed_mode & Multiplier[WIDTH-1];

        // Booth recoding of the current triplet; strobes stay low while idle
        if (state_q == RUN) begin
            case (triplet)
                3'b001, 3'b010: add_s = 1'b1;
                3'b011: begin
                    add_s = 1'b1;
                    dbl_s = 1'b1;
                end
                3'b100: begin
                    add_s = 1'b1;
                    sub_s = 1'b1;
                    dbl_s = 1'b1;
                end
                3'b101, 3'b110: begin
                    add_s = 1'b1;
                    sub_s = 1'b1;
                end
                default: ;
            endcase
        end

        m_single = {m_q[EW-1], m_q};
        m_double = {m_q, 1'b0};
        pp_mag   = dbl_s ? m_double : m_single;
        if (!add_s) begin
            pp = '0;
        end else if (sub_s) begin
            pp = AW'(0) - pp_mag;
        end else begin
            pp = pp_mag;
        end
        sum     = acc_q + pp;
        shifted = {{2{sum[AW-1]}}, sum, mq_q[EW:2]};

        case (state_q)
            IDLE: begin
                if (Request) begin
                    state_d = RUN;
                    done_d  = 1'b0;
                    m_d     = {mcand_sx, mcand_sx, Multiplicand};
                    acc_d   = '0;
                    mq_d    = {mplier_sx, mplier_sx, Multiplier, 1'b0};
                    cnt_d   = CW'(ITER - 1);
                end
            end
            RUN: begin
                acc_d = shifted[PW-1 -: AW];
                mq_d  = shifted[EW:0];
                cnt_d = cnt_q - CW'(1);
                // Last step: low 2*WIDTH bits above q-1 are the finished product
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    prod_d  = shifted[2*WIDTH:1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
